// File: rtl/core_pkg.sv
// Shared encodings for the RV32 decode stage: opcodes, control field encodings,
// the trap machine states and the execute-stage control bundle.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
  } ctrl_t;

endpackage

// File: rtl/main_alu_decoder.sv
// Combinational main + ALU decoder: instruction word to immediate format,
// execute-stage control bundle and an illegal-instruction flag.
module main_alu_decoder
  import core_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [1:0]  immSrc_o,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] aluCtl;
  logic       aluIllegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Subtract is only selected by funct7[5] on register-register ops; addi ignores it.
  always_comb begin
    aluCtl     = ALU_ADD;
    aluIllegal = 1'b0;
    case (funct3)
      3'b000:  aluCtl = ((opcode == OP_RTYPE) && instr_i[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  aluCtl = ALU_SLT;
      3'b110:  aluCtl = ALU_OR;
      3'b111:  aluCtl = ALU_AND;
      default: aluIllegal = 1'b1;
    endcase
  end

  always_comb begin
    immSrc_o  = IMM_I;
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl_o.regWrite   = 1'b1;
        ctrl_o.aluSrc     = 1'b1;
        ctrl_o.resultSrc  = RES_MEM;
        ctrl_o.aluControl = ALU_ADD;
      end
      OP_STORE: begin
        immSrc_o          = IMM_S;
        ctrl_o.memWrite   = 1'b1;
        ctrl_o.aluSrc     = 1'b1;
        ctrl_o.aluControl = ALU_ADD;
      end
      OP_RTYPE: begin
        if (aluIllegal) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.regWrite   = 1'b1;
          ctrl_o.aluControl = aluCtl;
        end
      end
      OP_IALU: begin
        if (aluIllegal) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.regWrite   = 1'b1;
          ctrl_o.aluSrc     = 1'b1;
          ctrl_o.aluControl = aluCtl;
        end
      end
      OP_BRANCH: begin
        // The extender format follows the opcode alone, even for an unsupported funct3.
        immSrc_o = IMM_B;
        if (funct3 != 3'b000) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.branch     = 1'b1;
          ctrl_o.aluControl = ALU_SUB;
        end
      end
      OP_LUI: begin
        immSrc_o         = IMM_U;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.resultSrc = RES_IMM;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: drives ImmSrcD, registers the ID/EX control bundle
// under stall/flush, and runs the RUN/TRAP machine with a saturating illegal counter.
module decode_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             TrapClr,
  output logic [1:0]       ImmSrcD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic             ValidE,
  output logic             IllegalE,
  output logic             Halted,
  output logic [CNT_W-1:0] IllegalCnt
);

  ctrl_t            decCtrl;
  logic             decIllegal;
  ctrl_t            ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  main_alu_decoder u_dec (
    .instr_i   (InstrD),
    .immSrc_o  (ImmSrcD),
    .ctrl_o    (decCtrl),
    .illegal_o (decIllegal)
  );

  // Flush beats stall; a plain stall freezes everything except a trap clear,
  // and a clear at the same edge as an illegal capture leaves the machine in RUN.
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    if (FlushE) begin
      ctrl_d    = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!StallE) begin
      ctrl_d    = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      if (ValidD && (state_q == RUN)) begin
        valid_d = 1'b1;
        if (decIllegal) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          ctrl_d = decCtrl;
        end
      end
    end
    if (TrapClr) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= RUN;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign RegWriteE   = ctrl_q.regWrite;
  assign MemWriteE   = ctrl_q.memWrite;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.aluSrc;
  assign ResultSrcE  = ctrl_q.resultSrc;
  assign ALUControlE = ctrl_q.aluControl;
  assign ValidE      = valid_q;
  assign IllegalE    = illegal_q;
  assign Halted      = (state_q == TRAP);
  assign IllegalCnt  = cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl (CNT_W=2): each step pushes a hand-derived
// expected E bundle, which is popped and compared one edge later.
module tb_decode_ctrl;

  localparam int CNT_W = 2;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_ORI  = 32'h0010E093;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_ADDI = 32'h40108093;

  logic             clk;
  logic             rst_n;
  logic [31:0]      InstrD;
  logic             ValidD, StallE, FlushE, TrapClr;
  logic [1:0]       ImmSrcD;
  logic             RegWriteE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic             ValidE, IllegalE, Halted;
  logic [CNT_W-1:0] IllegalCnt;

  int compared = 0;
  int mismatched = 0;
  logic [14:0] expQ[$];
  logic [1:0]  cnt;
  logic [31:0] illegalInstr[4];
  logic [1:0]  illegalImm[4];

  decode_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .TrapClr     (TrapClr),
    .ImmSrcD     (ImmSrcD),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ResultSrcE  (ResultSrcE),
    .ALUControlE (ALUControlE),
    .ValidE      (ValidE),
    .IllegalE    (IllegalE),
    .Halted      (Halted),
    .IllegalCnt  (IllegalCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing order: rw mw br as rs[1:0] alu[2:0] valid illegal halted cnt[1:0]
  function automatic logic [14:0] bundle(input logic rw, mw, br, as, input logic [1:0] rs,
                                         input logic [2:0] alu, input logic v, il, h,
                                         input logic [1:0] c);
    return {rw, mw, br, as, rs, alu, v, il, h, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic valid,
                               input logic stall, input logic flush, input logic clr,
                               input logic rstn, input logic [1:0] expImm,
                               input logic [14:0] expOut);
    logic [14:0] obs;
    @(negedge clk);
    InstrD  = instr;
    ValidD  = valid;
    StallE  = stall;
    FlushE  = flush;
    TrapClr = clr;
    rst_n   = rstn;
    #1;
    checkOutput({tag, "/imm"}, {13'b0, ImmSrcD}, {13'b0, expImm});
    expQ.push_back(expOut);
    @(posedge clk);
    #1;
    obs = {RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           ValidE, IllegalE, Halted, IllegalCnt};
    checkOutput(tag, obs, expQ.pop_front());
  endtask

  initial begin
    illegalInstr[0] = 32'h000080E7; illegalImm[0] = 2'b00;  // jalr
    illegalInstr[1] = 32'h002091B3; illegalImm[1] = 2'b00;  // sll
    illegalInstr[2] = 32'h00209463; illegalImm[2] = 2'b10;  // bne
    illegalInstr[3] = 32'h00000000; illegalImm[3] = 2'b00;
    InstrD = '0; ValidD = 1'b1; StallE = 1'b1; FlushE = 1'b1; TrapClr = 1'b0; rst_n = 1'b0;
    cnt = 2'd0;

    applyStimulus("reset0", I_ADD, 1, 1, 1, 0, 0, 2'b00, '0);
    applyStimulus("reset1", 32'h0, 1, 1, 1, 0, 0, 2'b00, '0);

    applyStimulus("add",  I_ADD,  1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b000,1,0,0,cnt));
    applyStimulus("sub",  I_SUB,  1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b001,1,0,0,cnt));
    applyStimulus("lw",   I_LW,   1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,1,2'b01,3'b000,1,0,0,cnt));
    applyStimulus("sw",   I_SW,   1, 0, 0, 0, 1, 2'b01, bundle(0,1,0,1,2'b00,3'b000,1,0,0,cnt));
    applyStimulus("beq",  I_BEQ,  1, 0, 0, 0, 1, 2'b10, bundle(0,0,1,0,2'b00,3'b001,1,0,0,cnt));
    applyStimulus("lui",  I_LUI,  1, 0, 0, 0, 1, 2'b11, bundle(1,0,0,0,2'b11,3'b000,1,0,0,cnt));
    applyStimulus("ori",  I_ORI,  1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,1,2'b00,3'b011,1,0,0,cnt));
    applyStimulus("slt",  I_SLT,  1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b101,1,0,0,cnt));
    applyStimulus("and",  I_AND,  1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b010,1,0,0,cnt));
    applyStimulus("addi30", I_ADDI, 1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,1,2'b00,3'b000,1,0,0,cnt));

    // Stall holds the add bundle while a store waits in decode.
    applyStimulus("addPreStall", I_ADD, 1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b000,1,0,0,cnt));
    for (int i = 0; i < 3; i++)
      applyStimulus("stallHold", I_SW, 1, 1, 0, 0, 1, 2'b01, bundle(1,0,0,0,2'b00,3'b000,1,0,0,cnt));
    applyStimulus("stallFlush", I_SW, 1, 1, 1, 0, 1, 2'b01, bundle(0,0,0,0,2'b00,3'b000,0,0,0,cnt));
    applyStimulus("validLow", I_ADD, 0, 0, 0, 0, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,0,0,0,cnt));

    cnt = 2'd1;
    applyStimulus("jal", I_JAL, 1, 0, 0, 0, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,1,1,1,cnt));
    applyStimulus("trapBubble", I_ADD, 1, 0, 0, 0, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,0,0,1,cnt));
    applyStimulus("trapClr", I_ADD, 1, 0, 0, 1, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,0,0,0,cnt));
    applyStimulus("addAfterClr", I_ADD, 1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b000,1,0,0,cnt));
    applyStimulus("flushIllegal", I_JAL, 1, 0, 1, 0, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,0,0,0,cnt));

    // Four more illegal captures push the 2-bit counter into saturation.
    for (int i = 0; i < 4; i++) begin
      cnt = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
      applyStimulus("illegal", illegalInstr[i], 1, 0, 0, 0, 1, illegalImm[i],
                    bundle(0,0,0,0,2'b00,3'b000,1,1,1,cnt));
      if (i == 0)
        applyStimulus("stallClr", I_ADD, 1, 1, 0, 1, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,1,1,0,cnt));
      else
        applyStimulus("clr", 32'h0, 0, 0, 0, 1, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,0,0,0,cnt));
    end
    applyStimulus("satClr", I_JAL, 1, 0, 0, 1, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,1,1,0,2'd3));
    applyStimulus("satTrap", I_JAL, 1, 0, 0, 0, 1, 2'b00, bundle(0,0,0,0,2'b00,3'b000,1,1,1,2'd3));
    applyStimulus("resetTrap", I_ADD, 1, 0, 0, 0, 0, 2'b00, '0);
    applyStimulus("addAfterRst", I_ADD, 1, 0, 0, 0, 1, 2'b00, bundle(1,0,0,0,2'b00,3'b000,1,0,0,2'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
